// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Two-port req/gnt arbiter in front of a single-port RAM. Supports
//            round-robin or fixed priority, bounded locking, and read-data return.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_BITS       = 8,
    parameter int DATA_BITS       = 8,
    parameter int FIXED_PRIORITY  = 0,
    parameter int MAX_LOCK_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 m0_req,
    input  logic                 m0_we,
    input  logic                 m0_lock,
    input  logic [ADDR_BITS-1:0] m0_addr,
    input  logic [DATA_BITS-1:0] m0_wdata,
    output logic                 m0_gnt,
    output logic                 m0_rvalid,
    output logic [DATA_BITS-1:0] m0_rdata,

    input  logic                 m1_req,
    input  logic                 m1_we,
    input  logic                 m1_lock,
    input  logic [ADDR_BITS-1:0] m1_addr,
    input  logic [DATA_BITS-1:0] m1_wdata,
    output logic                 m1_gnt,
    output logic                 m1_rvalid,
    output logic [DATA_BITS-1:0] m1_rdata,

    output logic                 ram_rd_en,
    output logic                 ram_wr_en,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [DATA_BITS-1:0] ram_wr_data,
    input  logic [DATA_BITS-1:0] ram_rd_data
);

    localparam int                 c_CNT_W     = $clog2(MAX_LOCK_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX   = c_CNT_W'(MAX_LOCK_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    localparam logic [1:0] c_UNLOCKED = 2'd0;
    localparam logic [1:0] c_LOCKED_0 = 2'd1;
    localparam logic [1:0] c_LOCKED_1 = 2'd2;

    logic [1:0]           r_state;
    logic [c_CNT_W-1:0]   r_lock_cnt;
    logic                 r_last_grant;
    logic                 r_force_other;
    logic                 r_rd_pending;
    logic                 r_rd_owner;

    logic                 w_gnt0;
    logic                 w_gnt1;
    logic                 w_xfer;
    logic                 w_xfer_port;
    logic                 w_xfer_we;
    logic                 w_xfer_lock;
    logic [ADDR_BITS-1:0] w_xfer_addr;
    logic [DATA_BITS-1:0] w_xfer_wdata;
    logic                 w_owner_req;
    logic [c_CNT_W-1:0]   w_cnt_next;

    // Grant decision; r_force_other makes the master that just lost a forced
    // lock yield a contested cycle even under fixed priority.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!reset) begin
            case (r_state)
                c_LOCKED_0: w_gnt0 = m0_req;
                c_LOCKED_1: w_gnt1 = m1_req;
                default: begin
                    if (m0_req && m1_req) begin
                        if (r_force_other || (FIXED_PRIORITY == 0)) begin
                            w_gnt0 = r_last_grant;
                            w_gnt1 = !r_last_grant;
                        end else begin
                            w_gnt0 = 1'b1;
                        end
                    end else begin
                        w_gnt0 = m0_req;
                        w_gnt1 = m1_req;
                    end
                end
            endcase
        end
    end

    assign w_xfer       = w_gnt0 | w_gnt1;
    assign w_xfer_port  = w_gnt1;
    assign w_xfer_we    = w_gnt1 ? m1_we    : m0_we;
    assign w_xfer_lock  = w_gnt1 ? m1_lock  : m0_lock;
    assign w_xfer_addr  = w_gnt1 ? m1_addr  : m0_addr;
    assign w_xfer_wdata = w_gnt1 ? m1_wdata : m0_wdata;
    assign w_owner_req  = (r_state == c_LOCKED_1) ? m1_req : m0_req;
    assign w_cnt_next   = r_lock_cnt + c_CNT_ONE;

    assign ram_rd_en   = w_xfer && !w_xfer_we;
    assign ram_wr_en   = w_xfer && w_xfer_we;
    assign ram_addr    = w_xfer ? w_xfer_addr : '0;
    assign ram_wr_data = (w_xfer && w_xfer_we) ? w_xfer_wdata : '0;

    assign m0_gnt    = w_gnt0;
    assign m1_gnt    = w_gnt1;
    assign m0_rvalid = !reset && r_rd_pending && !r_rd_owner;
    assign m1_rvalid = !reset && r_rd_pending && r_rd_owner;
    assign m0_rdata  = m0_rvalid ? ram_rd_data : '0;
    assign m1_rdata  = m1_rvalid ? ram_rd_data : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_UNLOCKED;
            r_lock_cnt    <= '0;
            r_last_grant  <= 1'b1;
            r_force_other <= 1'b0;
            r_rd_pending  <= 1'b0;
            r_rd_owner    <= 1'b0;
        end else begin
            r_force_other <= 1'b0;
            r_rd_pending  <= w_xfer && !w_xfer_we;
            if (w_xfer) begin
                r_rd_owner   <= w_xfer_port;
                r_last_grant <= w_xfer_port;
            end
            case (r_state)
                c_UNLOCKED: begin
                    if (w_xfer && w_xfer_lock) begin
                        // A one-beat limit means the lock expires on its first beat.
                        if (MAX_LOCK_CYCLES <= 1) begin
                            r_force_other <= 1'b1;
                        end else begin
                            r_state    <= w_xfer_port ? c_LOCKED_1 : c_LOCKED_0;
                            r_lock_cnt <= c_CNT_ONE;
                        end
                    end
                end
                c_LOCKED_0, c_LOCKED_1: begin
                    if (!w_owner_req || !w_xfer_lock) begin
                        r_state    <= c_UNLOCKED;
                        r_lock_cnt <= '0;
                    end else if (w_cnt_next >= c_CNT_MAX) begin
                        r_state       <= c_UNLOCKED;
                        r_lock_cnt    <= '0;
                        r_force_other <= 1'b1;
                    end else begin
                        r_lock_cnt <= w_cnt_next;
                    end
                end
                default: begin
                    r_state    <= c_UNLOCKED;
                    r_lock_cnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench for mem_port_arbiter with a RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       m0_req = 0, m0_we = 0, m0_lock = 0;
    logic [7:0] m0_addr = 0, m0_wdata = 0;
    logic       m1_req = 0, m1_we = 0, m1_lock = 0;
    logic [7:0] m1_addr = 0, m1_wdata = 0;
    logic       m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [7:0] m0_rdata, m1_rdata;
    logic       ram_rd_en, ram_wr_en;
    logic [7:0] ram_addr, ram_wr_data;
    logic [7:0] ram_rd_q;

    logic       fp_m0_gnt, fp_m0_rvalid, fp_m1_gnt, fp_m1_rvalid;
    logic [7:0] fp_m0_rdata, fp_m1_rdata;
    logic       fp_ram_rd_en, fp_ram_wr_en;
    logic [7:0] fp_ram_addr, fp_ram_wr_data;
    logic [7:0] fp_rd_data = 8'h00;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mem [256];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .FIXED_PRIORITY(0), .MAX_LOCK_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en), .ram_addr(ram_addr),
        .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_q)
    );

    mem_port_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .FIXED_PRIORITY(1), .MAX_LOCK_CYCLES(4)) dut_fp (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid), .m0_rdata(fp_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid), .m1_rdata(fp_m1_rdata),
        .ram_rd_en(fp_ram_rd_en), .ram_wr_en(fp_ram_wr_en), .ram_addr(fp_ram_addr),
        .ram_wr_data(fp_ram_wr_data), .ram_rd_data(fp_rd_data)
    );

    // RAM model, preloaded during reset with the words the tests read
    always @(posedge clk) begin
        if (reset) begin
            mem[8'h01] <= 8'h11;
            mem[8'h02] <= 8'h22;
            mem[8'h10] <= 8'hA5;
            mem[8'h20] <= 8'hC0;
            mem[8'h21] <= 8'hC1;
        end else if (ram_wr_en) begin
            mem[ram_addr] <= ram_wr_data;
        end
        if (ram_rd_en) ram_rd_q <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_req = 0; m0_we = 0; m0_lock = 0;
        m1_req = 0; m1_we = 0; m1_lock = 0;
    endtask

    task automatic test_reset();
        m0_req = 1; m0_addr = 8'h10; m1_req = 1; m1_addr = 8'h02;
        #1;
        vectors++;
        if ({m0_gnt, m1_gnt, ram_rd_en, ram_wr_en, m0_rvalid, m1_rvalid} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_strobes: got %b expected 000000",
                     {m0_gnt, m1_gnt, ram_rd_en, ram_wr_en, m0_rvalid, m1_rvalid});
        end
        vectors++;
        if ({ram_addr, ram_wr_data, m0_rdata, m1_rdata} !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h expected 00000000",
                     {ram_addr, ram_wr_data, m0_rdata, m1_rdata});
        end
        idle();
        tick();
        reset = 0;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rr_g1;
        logic       prev_g1;
        exp_rr_g1 = 4'b1010;  // bit i = port granted in cycle i
        prev_g1 = 0;
        m0_req = 1; m0_addr = 8'h01; m1_req = 1; m1_addr = 8'h02;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if ({m0_gnt, m1_gnt} !== {!exp_rr_g1[i], exp_rr_g1[i]}) begin
                miscompares++;
                $display("FAIL rr_gnt[%0d]: got %b expected %b", i, {m0_gnt, m1_gnt},
                         {!exp_rr_g1[i], exp_rr_g1[i]});
            end
            vectors++;
            if ({fp_m0_gnt, fp_m1_gnt} !== 2'b10) begin
                miscompares++;
                $display("FAIL fp_gnt[%0d]: got %b expected 10", i, {fp_m0_gnt, fp_m1_gnt});
            end
            vectors++;
            if (ram_addr !== (exp_rr_g1[i] ? 8'h02 : 8'h01)) begin
                miscompares++;
                $display("FAIL rr_addr[%0d]: got %h expected %h", i, ram_addr,
                         exp_rr_g1[i] ? 8'h02 : 8'h01);
            end
            if (i > 0) begin
                vectors++;
                if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !==
                    {!prev_g1, prev_g1, prev_g1 ? 8'h00 : 8'h11, prev_g1 ? 8'h22 : 8'h00}) begin
                    miscompares++;
                    $display("FAIL rr_rvalid[%0d]: got %b/%b %h/%h", i, m0_rvalid, m1_rvalid,
                             m0_rdata, m1_rdata);
                end
            end
            prev_g1 = exp_rr_g1[i];
            @(posedge clk);
        end
        #1;
        idle();
        #1;
        vectors++;
        if ({m0_rvalid, m1_rvalid, m1_rdata} !== {2'b01, 8'h22}) begin
            miscompares++;
            $display("FAIL rr_last_rvalid: got %b/%b %h expected 0/1 22", m0_rvalid, m1_rvalid, m1_rdata);
        end
        tick();
    endtask

    task automatic test_lock();
        m0_req = 1; m0_addr = 8'h20; m0_lock = 1;
        m1_req = 1; m1_addr = 8'h02;
        #1;
        vectors++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            miscompares++;
            $display("FAIL lock_beat1: got %b expected 10", {m0_gnt, m1_gnt});
        end
        tick();
        m0_addr = 8'h21; m0_lock = 0;
        #1;
        vectors++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m0_rdata} !== {3'b101, 8'hC0}) begin
            miscompares++;
            $display("FAIL lock_beat2: got %b%b%b %h expected 101 c0", m0_gnt, m1_gnt, m0_rvalid, m0_rdata);
        end
        tick();
        m0_req = 0;
        #1;
        vectors++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m0_rdata} !== {3'b011, 8'hC1}) begin
            miscompares++;
            $display("FAIL lock_release: got %b%b%b %h expected 011 c1", m0_gnt, m1_gnt, m0_rvalid, m0_rdata);
        end
        tick();
        m1_req = 0;
        m0_req = 1; m0_addr = 8'h20; m0_lock = 1;
        #1;
        vectors++;
        if ({m0_gnt, m1_rvalid, m1_rdata} !== {2'b11, 8'h22}) begin
            miscompares++;
            $display("FAIL lock_relock: got %b%b %h expected 11 22", m0_gnt, m1_rvalid, m1_rdata);
        end
        tick();
        m0_req = 0; m0_lock = 0; m1_req = 1;
        #1;
        vectors++;
        if ({m0_gnt, m1_gnt} !== 2'b00) begin
            miscompares++;
            $display("FAIL lock_idle_owner: got %b expected 00", {m0_gnt, m1_gnt});
        end
        tick();
        vectors++;
        if (m1_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL lock_idle_release: got %b expected 1", m1_gnt);
        end
        tick();
        idle();
        tick();
    endtask

    task automatic test_forced_unlock();
        m0_req = 1; m0_lock = 1; m0_addr = 8'h01;
        m1_req = 1; m1_addr = 8'h02;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if ({m0_gnt, m1_gnt} !== 2'b10) begin
                miscompares++;
                $display("FAIL forced_hold[%0d]: got %b expected 10", i, {m0_gnt, m1_gnt});
            end
            @(posedge clk);
        end
        #1;
        vectors++;
        if ({m0_gnt, m1_gnt} !== 2'b01) begin
            miscompares++;
            $display("FAIL forced_break: got %b expected 01", {m0_gnt, m1_gnt});
        end
        tick();
        idle();
        tick();
    endtask

    task automatic test_single_read();
        m0_req = 1; m0_addr = 8'h10;
        #1;
        vectors++;
        if ({m0_gnt, m1_gnt, ram_rd_en, ram_wr_en, ram_addr} !== {4'b1010, 8'h10}) begin
            miscompares++;
            $display("FAIL single_issue: got %b%b%b%b %h expected 1010 10",
                     m0_gnt, m1_gnt, ram_rd_en, ram_wr_en, ram_addr);
        end
        tick();
        m0_req = 0;
        #1;
        vectors++;
        if ({m0_rvalid, m0_rdata, m1_rvalid, m1_rdata, m1_gnt} !== {1'b1, 8'hA5, 1'b0, 8'h00, 1'b0}) begin
            miscompares++;
            $display("FAIL single_return: got %b %h %b %h expected 1 a5 0 00",
                     m0_rvalid, m0_rdata, m1_rvalid, m1_rdata);
        end
        tick();
    endtask

    task automatic test_write();
        m1_req = 1; m1_we = 1; m1_addr = 8'h7F; m1_wdata = 8'h3C;
        #1;
        vectors++;
        if ({m1_gnt, ram_wr_en, ram_rd_en, ram_addr, ram_wr_data} !== {3'b110, 8'h7F, 8'h3C}) begin
            miscompares++;
            $display("FAIL write_issue: got %b%b%b %h %h expected 110 7f 3c",
                     m1_gnt, ram_wr_en, ram_rd_en, ram_addr, ram_wr_data);
        end
        tick();
        idle();
        m0_req = 1; m0_addr = 8'h7F;
        #1;
        vectors++;
        if ({m0_rvalid, m1_rvalid, m0_gnt} !== 3'b001) begin
            miscompares++;
            $display("FAIL write_no_resp: got %b expected 001", {m0_rvalid, m1_rvalid, m0_gnt});
        end
        tick();
        m0_req = 0;
        #1;
        vectors++;
        if ({m0_rvalid, m0_rdata} !== {1'b1, 8'h3C}) begin
            miscompares++;
            $display("FAIL write_readback: got %b %h expected 1 3c", m0_rvalid, m0_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid_read();
        m0_req = 1; m0_addr = 8'h10; m0_lock = 1;
        tick();
        reset = 1; m1_req = 1; m1_addr = 8'h02;
        #1;
        vectors++;
        if ({m0_rvalid, m0_rdata, m0_gnt, m1_gnt, ram_rd_en, ram_addr} !== {1'b0, 8'h00, 3'b000, 8'h00}) begin
            miscompares++;
            $display("FAIL midrst_outputs: got %b %h %b%b%b %h expected 0 00 000 00",
                     m0_rvalid, m0_rdata, m0_gnt, m1_gnt, ram_rd_en, ram_addr);
        end
        tick();
        reset = 0; m0_lock = 0; m0_addr = 8'h01;
        #1;
        vectors++;
        if ({m0_gnt, m1_gnt, m0_rvalid} !== 3'b100) begin
            miscompares++;
            $display("FAIL midrst_first_grant: got %b expected 100", {m0_gnt, m1_gnt, m0_rvalid});
        end
        tick();
        idle();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle();
        reset = 1;
        tick();
        tick();
        test_reset();
        test_round_robin();
        test_lock();
        test_forced_unlock();
        test_single_read();
        test_write();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
